// File: rtl/timestamp_sequencer.sv
// Sequences Timestamper start/finish from host pulses and captures the running timestamp
// on probe events into a first-word-fall-through FIFO tagged with the probe index.
`ifndef COMM_FINISH
`define COMM_FINISH 4'h2
`endif

module timestamp_sequencer #(
    parameter int         NUM_PROBES = 4,
    parameter int         FIFO_DEPTH = 16,
    parameter logic [3:0] CMD_NONE   = 4'h0,
    parameter logic [3:0] CMD_FINISH = `COMM_FINISH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            host_start,
    input  logic                            host_stop,
    output logic                            busy,
    input  logic [NUM_PROBES-1:0]           probe_evt,
    output logic                            ts_start,
    output logic [3:0]                      ts_command,
    input  logic                            ts_done,
    input  logic [63:0]                     ts_timestamp,
    output logic                            rd_valid,
    input  logic                            rd_en,
    output logic [63:0]                     rd_data,
    output logic [$clog2(NUM_PROBES)-1:0]   rd_probe_id,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            overflow,
    output logic [15:0]                     dropped_count
);

    localparam int PW = $clog2(NUM_PROBES);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_FINISH} state_t;

    state_t                  state;
    logic [NUM_PROBES-1:0]   pending;
    logic [63:0]             hold [NUM_PROBES];
    logic [PW-1:0]           last_grant;
    logic [63:0]             data_mem [FIFO_DEPTH];
    logic [PW-1:0]           id_mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;

    logic                    flush;
    logic                    armed;
    logic                    gnt_any;
    logic [PW-1:0]           gnt_idx;
    logic                    push;
    logic                    pop;
    logic [NUM_PROBES-1:0]   accept;
    logic [16:0]             drop_sum;
    logic [16:0]             drop_total;

    assign flush    = (state == S_IDLE) && host_start;
    assign armed    = (state == S_RUN);
    assign rd_valid = (fifo_count != '0);
    assign rd_data     = rd_valid ? data_mem[rd_ptr] : '0;
    assign rd_probe_id = rd_valid ? id_mem[rd_ptr] : '0;
    assign push = gnt_any && !flush;
    assign pop  = rd_en && rd_valid && !flush;
    assign drop_total = {1'b0, dropped_count} + drop_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            ts_start   <= 1'b0;
            ts_command <= CMD_NONE;
            busy       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (host_start) begin
                    state    <= S_START;
                    ts_start <= 1'b1;
                    busy     <= 1'b1;
                end
                S_START: begin
                    state    <= S_RUN;
                    ts_start <= 1'b0;
                end
                S_RUN: if (host_stop) begin
                    state      <= S_FINISH;
                    ts_command <= CMD_FINISH;
                end
                S_FINISH: if (ts_done) begin
                    state      <= S_IDLE;
                    ts_command <= CMD_NONE;
                    busy       <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Round-robin: descending walk so the pending probe closest after last_grant wins.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = NUM_PROBES - 1; k >= 0; k--) begin
            idx = int'(last_grant) + 1 + k;
            if (idx >= NUM_PROBES) idx = idx - NUM_PROBES;
            if (pending[PW'(idx)] && (fifo_count < CW'(FIFO_DEPTH))) begin
                gnt_any = 1'b1;
                gnt_idx = PW'(idx);
            end
        end
    end

    // A probe granted this cycle frees its hold register, so a fresh event is accepted.
    always_comb begin
        accept   = '0;
        drop_sum = '0;
        for (int i = 0; i < NUM_PROBES; i++) begin
            if (armed && probe_evt[i]) begin
                if (!pending[i] || (gnt_any && (gnt_idx == PW'(i))))
                    accept[i] = 1'b1;
                else
                    drop_sum = drop_sum + 17'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending       <= '0;
            last_grant    <= PW'(NUM_PROBES - 1);
            overflow      <= 1'b0;
            dropped_count <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_count    <= '0;
            for (int i = 0; i < NUM_PROBES; i++) hold[i] <= '0;
        end else if (flush) begin
            pending       <= '0;
            overflow      <= 1'b0;
            dropped_count <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_count    <= '0;
        end else begin
            for (int i = 0; i < NUM_PROBES; i++) begin
                if (accept[i]) begin
                    pending[i] <= 1'b1;
                    hold[i]    <= ts_timestamp;
                end else if (push && (gnt_idx == PW'(i))) begin
                    pending[i] <= 1'b0;
                end
            end
            if (push) begin
                wr_ptr     <= wr_ptr + 1'b1;
                last_grant <= gnt_idx;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
            if (drop_sum != '0) begin
                overflow      <= 1'b1;
                dropped_count <= (drop_total > 17'h0FFFF) ? 16'hFFFF : drop_total[15:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= hold[gnt_idx];
            id_mem[wr_ptr]   <= gnt_idx;
        end
    end

endmodule
